// File: rtl/fazyrv_pkg.sv
// Shared types for the FazyRV data-memory address path: access size and
// address deserializer state.
package fazyrv_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        REQ
    } state_e;

endpackage

// File: rtl/fazyrv_sel_gen.sv
// Byte-lane select and misalignment detection from access size and the two
// address LSBs. Purely combinational so the store-data path can share it.
module fazyrv_sel_gen
    import fazyrv_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] adr_lsb,
    output logic [3:0] sel,
    output logic       misalign
);

    // Reserved size encoding falls through to the word case.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign sel[gi] = (size == SIZE_B) ? (adr_lsb == 2'(gi)) :
                             (size == SIZE_H) ? (adr_lsb[1] == 1'(gi / 2)) :
                                                1'b1;
        end
    endgenerate

    assign misalign = (size == SIZE_B) ? 1'b0 :
                      (size == SIZE_H) ? adr_lsb[0] :
                                         (adr_lsb != 2'b00);

endmodule

// File: rtl/fazyrv_adr_deser.sv
// Collects a chunk-serial effective address LSB-first, checks alignment and
// issues a single bus request that is held until acknowledged.
module fazyrv_adr_deser
    import fazyrv_pkg::*;
#(
    parameter int CHUNKSIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           size_i,
    input  logic                 shift_i,
    input  logic [CHUNKSIZE-1:0] din_i,
    output logic [31:0]          wb_adr_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           adr_lsb_o
);

    localparam int BEATS = 32 / CHUNKSIZE;
    localparam int CW    = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_e         state_reg, state_next;
    logic [31:0]    shreg_reg;
    logic [CW-1:0]  cnt_reg;
    logic [1:0]     size_reg;
    logic           done_reg;

    logic [3:0]     sel;
    logic           misalign;

    fazyrv_sel_gen u_sel_gen (
        .size     (size_reg),
        .adr_lsb  (shreg_reg[1:0]),
        .sel      (sel),
        .misalign (misalign)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = SHIFT;
            SHIFT:   if (shift_i && (cnt_reg == LAST_BEAT)) state_next = CHECK;
            CHECK:   state_next = misalign ? IDLE : REQ;
            REQ:     if (wb_ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            size_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == REQ) && wb_ack_i;
            if (state_reg == IDLE && start_i) begin
                size_reg <= size_i;
                cnt_reg  <= '0;
            end
            if (state_reg == SHIFT && shift_i) begin
                shreg_reg <= {din_i, shreg_reg[31:CHUNKSIZE]};
                // Saturate on the final beat; the counter is cleared at start.
                if (cnt_reg != LAST_BEAT) cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign busy_o    = (state_reg != IDLE);
    assign err_o     = (state_reg == CHECK) && misalign;
    assign wb_stb_o  = (state_reg == REQ);
    assign wb_sel_o  = wb_stb_o ? sel : 4'b0000;
    assign wb_adr_o  = {shreg_reg[31:2], 2'b00};
    assign adr_lsb_o = shreg_reg[1:0];
    assign done_o    = done_reg;

endmodule

// File: tb/tb_fazyrv_adr_deser.sv
// Randomised self-checking bench: four deserializers (CHUNKSIZE 1,2,4,8)
// driven one at a time and compared against a size/address rule model.
module tb_fazyrv_adr_deser;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [4];
    logic        shift [4];
    logic [1:0]  size;
    logic [7:0]  din;
    logic        ack;

    logic [31:0] adr   [4];
    logic [3:0]  sel   [4];
    logic        stb   [4];
    logic        busy  [4];
    logic        done  [4];
    logic        err   [4];
    logic [1:0]  lsb   [4];

    int n_checks = 0;
    int n_fail   = 0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            localparam int CS = 1 << gi;
            fazyrv_adr_deser #(.CHUNKSIZE(CS)) dut (
                .clk_i     (clk),
                .rst_i     (rst),
                .start_i   (start[gi]),
                .size_i    (size),
                .shift_i   (shift[gi]),
                .din_i     (din[CS-1:0]),
                .wb_adr_o  (adr[gi]),
                .wb_sel_o  (sel[gi]),
                .wb_stb_o  (stb[gi]),
                .wb_ack_i  (ack),
                .busy_o    (busy[gi]),
                .done_o    (done[gi]),
                .err_o     (err[gi]),
                .adr_lsb_o (lsb[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules: lane selects and alignment from size and byte offset.
    function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                  output logic mis, output logic [3:0] esel);
        int off;
        off = int'(a % 4);
        case (sz)
            2'd0: begin mis = 1'b0;        esel = 4'(1 << off); end
            2'd1: begin mis = (off % 2 == 1); esel = 4'(3 << (off - off % 2)); end
            default: begin mis = (off != 0); esel = 4'hF; end
        endcase
    endfunction

    task automatic check_reset_outs(input int k, input string tag);
        check({tag, "_adr"},  adr[k],  32'h0);
        check({tag, "_sel"},  32'(sel[k]), 32'h0);
        check({tag, "_stb"},  32'(stb[k]), 32'h0);
        check({tag, "_busy"}, 32'(busy[k]), 32'h0);
        check({tag, "_done"}, 32'(done[k]), 32'h0);
        check({tag, "_err"},  32'(err[k]), 32'h0);
        check({tag, "_lsb"},  32'(lsb[k]), 32'h0);
    endtask

    // abort: 0 none, 1 reset during shift beat 7, 2 reset during REQ
    task automatic run_txn(input int k, input logic [31:0] a, input logic [1:0] sz,
                           input bit stall, input int ack_dly, input bit spurious,
                           input int abort);
        int cs, beats;
        logic mis;
        logic [3:0] esel;
        cs    = 1 << k;
        beats = 32 / cs;
        model(a, sz, mis, esel);

        @(negedge clk);
        size = sz; start[k] = 1'b1; ack = 1'b0;
        @(negedge clk);
        start[k] = 1'b0;
        size = 2'($urandom);
        check("shift_busy", 32'(busy[k]), 32'h1);
        check("shift_stb",  32'(stb[k]),  32'h0);

        for (int j = 0; j < beats; j++) begin
            if (stall) begin
                shift[k] = 1'b0; din = 8'($urandom);
                @(negedge clk);
            end
            if (abort == 1 && j == 7) begin
                shift[k] = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_outs(k, "rst_shift");
                $display("txn cs=%0d adr=%h size=%0d: reset during shift", cs, a, sz);
                return;
            end
            shift[k] = 1'b1;
            din = 8'((a >> (j * cs)) & ((32'h1 << cs) - 1));
            @(negedge clk);
        end
        shift[k] = 1'b0; din = 8'($urandom);

        // CHECK cycle: one cycle after the last beat
        check("chk_err",  32'(err[k]),  32'(mis));
        check("chk_stb",  32'(stb[k]),  32'h0);
        check("chk_busy", 32'(busy[k]), 32'h1);
        check("chk_done", 32'(done[k]), 32'h0);
        check("chk_adr",  adr[k], a & 32'hFFFF_FFFC);
        check("chk_lsb",  32'(lsb[k]), 32'(a[1:0]));
        ack = 1'($urandom);
        @(negedge clk);

        if (mis) begin
            ack = 1'b0;
            check("mis_err",  32'(err[k]),  32'h0);
            check("mis_busy", 32'(busy[k]), 32'h0);
            check("mis_stb",  32'(stb[k]),  32'h0);
            check("mis_done", 32'(done[k]), 32'h0);
            $display("txn cs=%0d adr=%h size=%0d: misaligned", cs, a, sz);
            return;
        end

        for (int d = 0; d <= ack_dly; d++) begin
            check("req_stb",  32'(stb[k]),  32'h1);
            check("req_sel",  32'(sel[k]),  32'(esel));
            check("req_adr",  adr[k], a & 32'hFFFF_FFFC);
            check("req_lsb",  32'(lsb[k]), 32'(a[1:0]));
            check("req_done", 32'(done[k]), 32'h0);
            check("req_err",  32'(err[k]),  32'h0);
            if (abort == 2) begin
                ack = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_outs(k, "rst_req");
                $display("txn cs=%0d adr=%h size=%0d: reset during request", cs, a, sz);
                return;
            end
            if (d < ack_dly) begin
                ack = 1'b0;
                start[k] = spurious; shift[k] = spurious; din = 8'($urandom);
            end else begin
                ack = 1'b1;
                start[k] = 1'b0; shift[k] = 1'b0;
            end
            @(negedge clk);
        end
        ack = 1'b0;
        check("ack_stb",  32'(stb[k]),  32'h0);
        check("ack_done", 32'(done[k]), 32'h1);
        check("ack_busy", 32'(busy[k]), 32'h0);
        check("ack_err",  32'(err[k]),  32'h0);
        check("ack_sel",  32'(sel[k]),  32'h0);
        @(negedge clk);
        check("post_done", 32'(done[k]), 32'h0);
        check("post_busy", 32'(busy[k]), 32'h0);
        $display("txn cs=%0d adr=%h size=%0d sel=%b ack_dly=%0d: done", cs, a, sz, esel, ack_dly);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; size = '0; din = '0; ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start[k] = 1'b0; shift[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) check_reset_outs(k, "init");
        rst = 1'b0;

        run_txn(1, 32'h0000_1234, 2'd2, 1'b0, 0, 1'b0, 0);
        run_txn(1, 32'h8000_0003, 2'd0, 1'b1, 0, 1'b0, 0);
        run_txn(1, 32'h0000_0101, 2'd1, 1'b0, 0, 1'b0, 0);
        run_txn(1, 32'h0000_1234, 2'd2, 1'b0, 5, 1'b1, 0);
        run_txn(1, 32'h1357_9BDF, 2'd0, 1'b0, 0, 1'b0, 1);
        run_txn(1, 32'hCAFE_BAB0, 2'd2, 1'b0, 0, 1'b0, 0);
        run_txn(1, 32'h2468_ACE0, 2'd2, 1'b0, 3, 1'b0, 2);
        run_txn(1, 32'hDEAD_BEEC, 2'd2, 1'b0, 1, 1'b0, 0);
        run_txn(0, 32'h0000_1234, 2'd2, 1'b0, 0, 1'b0, 0);
        run_txn(2, 32'h0000_1234, 2'd2, 1'b0, 0, 1'b0, 0);
        run_txn(3, 32'h0000_1234, 2'd2, 1'b0, 0, 1'b0, 0);
        run_txn(3, 32'h0000_0002, 2'd3, 1'b0, 0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            run_txn(int'($urandom_range(3, 0)), a, 2'($urandom), 1'($urandom),
                    int'($urandom_range(4, 0)), 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
